// File: rtl/tag_frame_buff.sv
// Frame-atomic AXIS-to-EBI buffer: frames are committed behind a header word
// and popped READ_WIDTH bits at a time on rd_ena rising edges.
module tag_frame_buff #(
  parameter int NUM_TAGS      = 10,
  parameter int NUM_CHANNELS  = 4,
  parameter int CHANNEL_WIDTH = 64,
  parameter int FIFO_DEPTH    = 128,
  parameter int READ_WIDTH    = 16,
  parameter int MAX_BEATS     = 64,
  parameter int CNT_WIDTH     = 16,
  parameter string MEMORY_TYPE = "block"
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_TAGS-1:0]                   s_axis_tuser,
  input  logic                                  s_axis_tlast,
  input  logic                                  rd_ena,
  output logic                                  rd_ready,
  output logic [READ_WIDTH-1:0]                 rd_data,
  output logic [CNT_WIDTH-1:0]                  frame_count,
  output logic [CNT_WIDTH-1:0]                  drop_count
);

  localparam int DW = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int S  = DW / READ_WIDTH;
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam logic [AW:0]   FREE_MAX = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [15:0]   MAXB     = 16'(MAX_BEATS);
  localparam logic [SW-1:0] SLAST    = SW'(S - 1);

  typedef enum logic [1:0] {IDLE, RECV, HDR, DROP} st_t;

  st_t             st_q, st_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [AW-1:0]   hdr_ptr_q, hdr_ptr_d;
  logic [AW-1:0]   rd_ptr_q;
  logic [15:0]     n_q, n_d;
  logic [NUM_TAGS-1:0] tuser_q, tuser_d;
  logic [CNT_WIDTH-1:0] fc_q, fc_d, dc_q;

  logic            rd_ena_q, pop_q, rd_hdr_q;
  logic [SW-1:0]   sl_q;
  logic [15:0]     rem_q;
  logic [DW-1:0]   rdword_q;
  logic [READ_WIDTH-1:0] rd_data_q;
  logic [S-1:0][READ_WIDTH-1:0] slices;

  logic            we, tready_c, drop_inc, commit, frame_done, pop_c;
  logic [AW-1:0]   waddr, used;
  logic [DW-1:0]   wdata, hdr_w;
  logic [AW:0]     free;

  assign used = wr_ptr_q - rd_ptr_q;
  assign free = FREE_MAX - {1'b0, used};

  always_comb begin
    hdr_w = '0;
    hdr_w[15:0] = n_q;
    hdr_w[16 +: NUM_TAGS] = tuser_q;
  end

  always_comb begin
    st_d = st_q;
    wr_ptr_d = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    hdr_ptr_d = hdr_ptr_q;
    n_d = n_q;
    tuser_d = tuser_q;
    we = 1'b0;
    waddr = wr_ptr_q;
    wdata = s_axis_tdata;
    tready_c = 1'b0;
    drop_inc = 1'b0;
    commit = 1'b0;
    case (st_q)
      IDLE: begin
        tready_c = (free >= (AW+1)'(2));
        if (s_axis_tvalid && tready_c) begin
          hdr_ptr_d = wr_ptr_q;
          we = 1'b1;
          waddr = wr_ptr_q + AW'(1);
          wr_ptr_d = wr_ptr_q + AW'(2);
          n_d = 16'd1;
          if (s_axis_tlast) begin
            tuser_d = s_axis_tuser;
            st_d = HDR;
          end else begin
            st_d = RECV;
          end
        end
      end
      RECV: begin
        tready_c = 1'b1;
        if (s_axis_tvalid) begin
          if (free == '0 || n_q == MAXB) begin
            // Roll back to the last commit so nothing of this frame survives
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
            st_d = s_axis_tlast ? IDLE : DROP;
          end else begin
            we = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            n_d = n_q + 16'd1;
            if (s_axis_tlast) begin
              tuser_d = s_axis_tuser;
              st_d = HDR;
            end
          end
        end
      end
      HDR: begin
        we = 1'b1;
        waddr = hdr_ptr_q;
        wdata = hdr_w;
        commit_ptr_d = wr_ptr_q;
        commit = 1'b1;
        st_d = IDLE;
      end
      DROP: begin
        tready_c = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign s_axis_tready = tready_c & ~rst;

  always_comb begin
    fc_d = fc_q;
    if (commit && !frame_done) fc_d = fc_q + CNT_WIDTH'(1);
    else if (!commit && frame_done) fc_d = fc_q - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      wr_ptr_q <= '0;
      commit_ptr_q <= '0;
      hdr_ptr_q <= '0;
      n_q <= '0;
      tuser_q <= '0;
      fc_q <= '0;
      dc_q <= '0;
    end else begin
      st_q <= st_d;
      wr_ptr_q <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      hdr_ptr_q <= hdr_ptr_d;
      n_q <= n_d;
      tuser_q <= tuser_d;
      fc_q <= fc_d;
      if (drop_inc && dc_q != '1) dc_q <= dc_q + CNT_WIDTH'(1);
    end
  end

  if (MEMORY_TYPE == "distributed") begin : g_dist
    (* ram_style = "distributed" *) logic [DW-1:0] mem [FIFO_DEPTH];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdword_q <= mem[rd_ptr_q];
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [DW-1:0] mem [FIFO_DEPTH];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdword_q <= mem[rd_ptr_q];
    end
  end

  assign slices = rdword_q;
  assign pop_c = rd_ena & ~rd_ena_q & (fc_q != '0);
  assign frame_done = pop_q && (sl_q == SLAST) && !rd_hdr_q
                      && (rem_q == 16'd1);

  // Header word carries N; rem_q counts data words left in the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ena_q <= 1'b0;
      pop_q <= 1'b0;
      sl_q <= '0;
      rd_hdr_q <= 1'b1;
      rem_q <= '0;
      rd_ptr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_ena_q <= rd_ena;
      pop_q <= pop_c;
      if (pop_q) begin
        rd_data_q <= slices[sl_q];
        if (sl_q == SLAST) begin
          sl_q <= '0;
          rd_ptr_q <= rd_ptr_q + AW'(1);
          if (rd_hdr_q) begin
            rem_q <= rdword_q[15:0];
            rd_hdr_q <= 1'b0;
          end else begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) rd_hdr_q <= 1'b1;
          end
        end else begin
          sl_q <= sl_q + SW'(1);
        end
      end
    end
  end

  assign rd_data = rd_data_q;
  assign rd_ready = (fc_q != '0);
  assign frame_count = fc_q;
  assign drop_count = dc_q;

endmodule

// File: tb/tb_tag_frame_buff.sv
// Scoreboard bench for tag_frame_buff: frames are modelled as expected read
// slices pushed on send and popped on every MPU read.
module tb_tag_frame_buff;

  localparam int NT = 10;
  localparam int DW = 256;
  localparam int RW = 16;
  localparam int S  = DW / RW;

  logic clk = 1'b0;
  logic rst;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic [NT-1:0] s_axis_tuser;
  logic rd_ena, rd_ready;
  logic [RW-1:0] rd_data;
  logic [15:0] frame_count, drop_count;

  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  always #5 clk = ~clk;

  tag_frame_buff #(
    .NUM_TAGS(NT), .NUM_CHANNELS(4), .CHANNEL_WIDTH(64),
    .FIFO_DEPTH(16), .READ_WIDTH(RW), .MAX_BEATS(8),
    .CNT_WIDTH(16), .MEMORY_TYPE("block")
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast),
    .rd_ena(rd_ena), .rd_ready(rd_ready), .rd_data(rd_data),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  task automatic push_word(input logic [DW-1:0] w);
    for (int s = 0; s < S; s++) exp_q.push_back(w[s*RW +: RW]);
  endtask

  task automatic send_beat(input logic [DW-1:0] w, input logic last,
                           input logic [NT-1:0] tu);
    int guard;
    s_axis_tdata = w;
    s_axis_tuser = tu;
    s_axis_tlast = last;
    s_axis_tvalid = 1'b1;
    guard = 0;
    while (s_axis_tready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("FAIL tready_timeout got=%b want=1", s_axis_tready);
    end
    @(negedge clk);
  endtask

  task automatic drive_frame(input int n, input logic [NT-1:0] tu,
                             input bit keep);
    logic [DW-1:0] w;
    logic [DW-1:0] hdr;
    logic [DW-1:0] beats[$];
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom();
      send_beat(w, (i == n-1), tu);
      beats.push_back(w);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    if (keep) begin
      hdr = '0;
      hdr[15:0] = 16'(n);
      hdr[16 +: NT] = tu;
      push_word(hdr);
      foreach (beats[i]) push_word(beats[i]);
    end
  endtask

  task automatic pop_check(input string name);
    logic [RW-1:0] e;
    rd_ena = 1'b1;
    @(negedge clk);
    rd_ena = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s no_expected got=%h", name, rd_data);
    end else begin
      e = exp_q.pop_front();
      if (rd_data !== e) begin
        failures++;
        $display("FAIL %s rd_data got=%h want=%h", name, rd_data, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic read_n(input int n, input string name);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (rd_ready !== 1'b1 && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) begin
        checks++;
        failures++;
        $display("FAIL %s rd_ready_timeout got=%b want=1", name, rd_ready);
        return;
      end
      pop_check(name);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] fc,
                           input logic [15:0] dc, input logic rdy);
    checks++;
    if (frame_count !== fc || drop_count !== dc || rd_ready !== rdy) begin
      failures++;
      $display("FAIL %s got fc=%0d dc=%0d rdy=%b want fc=%0d dc=%0d rdy=%b",
               name, frame_count, drop_count, rd_ready, fc, dc, rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    s_axis_tuser = '0;
    rd_ena = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_hold got tready=%b rd_data=%h want 0 0",
               s_axis_tready, rd_data);
    end
    check_cnt("reset_cnt", 16'd0, 16'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release tready got=%b want=1", s_axis_tready);
    end
  endtask

  task automatic test_empty_pops();
    for (int i = 0; i < 4; i++) begin
      rd_ena = 1'b1;
      @(negedge clk);
      rd_ena = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (rd_data !== '0) begin
        failures++;
        $display("FAIL empty_pop rd_data got=%h want=0", rd_data);
      end
    end
    check_cnt("empty_cnt", 16'd0, 16'd0, 1'b0);
  endtask

  task automatic test_single();
    drive_frame(3, 10'h020, 1'b1);
    repeat (2) @(negedge clk);
    check_cnt("single_commit", 16'd1, 16'd0, 1'b1);
    read_n(4*S, "single_read");
    check_cnt("single_done", 16'd0, 16'd0, 1'b0);
  endtask

  task automatic test_overflow();
    drive_frame(8, 10'h001, 1'b1);
    drive_frame(8, 10'h002, 1'b0);
    repeat (2) @(negedge clk);
    check_cnt("ovf_drop", 16'd1, 16'd1, 1'b1);
    read_n(9*S, "ovf_read_a");
    check_cnt("ovf_a_done", 16'd0, 16'd1, 1'b0);
    drive_frame(2, 10'h3ff, 1'b1);
    repeat (2) @(negedge clk);
    check_cnt("ovf_next", 16'd1, 16'd1, 1'b1);
    read_n(3*S, "ovf_read_c");
    check_cnt("ovf_c_done", 16'd0, 16'd1, 1'b0);
  endtask

  task automatic test_max_beats();
    drive_frame(9, 10'h100, 1'b0);
    repeat (2) @(negedge clk);
    check_cnt("max_drop", 16'd0, 16'd2, 1'b0);
    drive_frame(8, 10'h155, 1'b1);
    repeat (2) @(negedge clk);
    check_cnt("max_commit", 16'd1, 16'd2, 1'b1);
    read_n(9*S, "max_read");
    check_cnt("max_done", 16'd0, 16'd2, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_frame(6, 10'h0c3, 1'b1);
    fork
      read_n(11*S, "b2b_read");
      begin
        drive_frame(3, 10'h21a, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (frame_count !== 16'd2) begin
          failures++;
          $display("FAIL b2b_peak fc got=%0d want=2", frame_count);
        end
      end
    join
    check_cnt("b2b_done", 16'd0, 16'd2, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    drive_frame(4, 10'h081, 1'b1);
    repeat (2) @(negedge clk);
    read_n(5, "rstmid_pre");
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom();
      send_beat(w, 1'b0, 10'h3c0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0 || rd_data !== '0) begin
      failures++;
      $display("FAIL rstmid_out got tready=%b rd_data=%h want 0 0",
               s_axis_tready, rd_data);
    end
    check_cnt("rstmid_cnt", 16'd0, 16'd0, 1'b0);
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_frame(2, 10'h0aa, 1'b1);
    repeat (2) @(negedge clk);
    check_cnt("rstmid_commit", 16'd1, 16'd0, 1'b1);
    read_n(3*S, "rstmid_read");
    check_cnt("rstmid_done", 16'd0, 16'd0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty_pops();
    test_single();
    test_overflow();
    test_max_beats();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
